// File: rtl/fetch_arbiter.sv
// fetch_arbiter
//   Shares one single-port instruction memory (1-cycle registered read)
//   between NUM_REQ fetch ports using round-robin arbitration. A host can
//   take over the memory for program loading. A saturating counter records
//   cycles in which two or more ports competed for a grant.
//
// Ports
//   clk, reset (async, active-low)
//   req_valid / req_addr      : per-port fetch request and packed addresses
//   req_ready                 : one-hot combinational grant
//   req_data / req_data_valid : shared read data, registered one-hot owner
//   load_req / load_ack       : host program-load handshake
//   host_we/host_addr/host_wdata : host write port (used only in load mode)
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : instruction BRAM port
//   clear_stats / conflict_count : conflict statistics
//
// state  | meaning
// S_RUN  | round-robin arbitration between fetch ports
// S_LOAD | host owns the memory, fetch grants suspended
module fetch_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [MEMORY_WIDTH-1:0]                req_data,
  output logic [NUM_REQ-1:0]                     req_data_valid,
  input  logic                                   load_req,
  output logic                                   load_ack,
  input  logic                                   host_we,
  input  logic [MEMORY_ADDR_WIDTH-1:0]           host_addr,
  input  logic [MEMORY_WIDTH-1:0]                host_wdata,
  output logic                                   mem_en,
  output logic                                   mem_we,
  output logic [MEMORY_ADDR_WIDTH-1:0]           mem_addr,
  output logic [MEMORY_WIDTH-1:0]                mem_wdata,
  input  logic [MEMORY_WIDTH-1:0]                mem_rdata,
  input  logic                                   clear_stats,
  output logic [CNT_WIDTH-1:0]                   conflict_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]       rdv_q;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic                     grant_any;
  logic [PTR_W-1:0]         grant_idx;
  logic [NUM_REQ-1:0]       grant_oh;
  logic                     multi_req;
  logic                     arb_en;
  logic [MEMORY_ADDR_WIDTH-1:0] sel_addr;

  // Round-robin search starting at rr_ptr; the index wraps modulo NUM_REQ
  // so non-power-of-two port counts work too.
  always_comb begin
    int idx;
    int pc;
    idx       = 0;
    pc        = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
      if (req_valid[k]) pc = pc + 1;
    end
    multi_req = (pc >= 2);
  end

  always_comb begin
    sel_addr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == PTR_W'(k)) sel_addr = req_addr[k*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
    end
  end

  // reset is folded into the combinational outputs so nothing is granted
  // or written while the block is held in reset.
  assign arb_en   = reset && (state_q == S_RUN) && !load_req;
  assign load_ack = reset && (state_q == S_LOAD);

  always_comb begin
    grant_oh = '0;
    if (arb_en && grant_any) grant_oh[grant_idx] = 1'b1;
  end

  assign req_ready      = grant_oh;
  assign req_data       = mem_rdata;
  assign req_data_valid = rdv_q;
  assign conflict_count = cnt_q;

  assign mem_en    = load_ack ? host_we : (|grant_oh);
  assign mem_we    = load_ack & host_we;
  assign mem_addr  = load_ack ? host_addr : ((|grant_oh) ? sel_addr : '0);
  assign mem_wdata = load_ack ? host_wdata : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_RUN:   if (load_req)  state_d = S_LOAD;
      S_LOAD:  if (!load_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    if (|grant_oh) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
    if (clear_stats) begin
      cnt_d = '0;
    end else if ((|grant_oh) && multi_req && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      rr_ptr_q <= '0;
      rdv_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rdv_q    <= grant_oh;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Testbench for fetch_arbiter: behavioural BRAM, scoreboard of expected
// read returns, round-robin reference model. Counter width is reduced so
// saturation can be reached quickly.
module tb_fetch_arbiter;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int AW = 11;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [MW-1:0]     req_data;
  logic [N-1:0]      req_data_valid;
  logic              load_req;
  logic              load_ack;
  logic              host_we;
  logic [AW-1:0]     host_addr;
  logic [MW-1:0]     host_wdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [MW-1:0]     mem_wdata;
  logic [MW-1:0]     mem_rdata;
  logic              clear_stats;
  logic [CW-1:0]     conflict_count;

  always #5 clk = ~clk;

  fetch_arbiter #(
    .NUM_REQ(N), .MEMORY_WIDTH(MW), .MEMORY_ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .req_data(req_data), .req_data_valid(req_data_valid),
    .load_req(load_req), .load_ack(load_ack),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .clear_stats(clear_stats), .conflict_count(conflict_count)
  );

  function automatic logic [MW-1:0] pat(input logic [AW-1:0] a);
    return {a, 5'b0} ^ 16'h3C5A;
  endfunction

  // Behavioural single-port BRAM with registered read.
  logic [MW-1:0] mem     [0:2047];
  logic          mem_vld [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]     <= mem_wdata;
        mem_vld[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= (mem_vld[mem_addr] === 1'b1) ? mem[mem_addr] : pat(mem_addr);
      end
    end
  end

  // Bench-side expectation of memory contents.
  logic [MW-1:0] exp_mem [int];
  function automatic logic [MW-1:0] exp_rd(input logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : pat(a);
  endfunction

  typedef struct {
    logic [N-1:0]  who;
    logic [MW-1:0] data;
  } rd_t;
  rd_t sbq[$];

  int            n_cmp = 0;
  int            n_bad = 0;
  int            ptr_m;
  logic [CW-1:0] cnt_m;

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int k = 0; k < N; k++) if (v[k]) c++;
    return c;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int g);
    return req_addr[g*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  // Advance the reference model for the cycle about to be clocked.
  task automatic model_cycle(input int g);
    rd_t e;
    e.who  = '0;
    e.data = '0;
    if (g >= 0) begin
      e.who[g] = 1'b1;
      e.data   = exp_rd(addr_of(g));
      ptr_m    = (g + 1) % N;
    end
    sbq.push_back(e);
    if (clear_stats) cnt_m = '0;
    else if (g >= 0 && popc(req_valid) >= 2 && cnt_m != '1) cnt_m = cnt_m + 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '1; load_req = 1'b0; host_we = 1'b1;
    host_addr = 11'h020; host_wdata = 16'hFFFF; clear_stats = 1'b0;
    set_addr(0, 11'h005); set_addr(1, 11'h123); set_addr(2, 11'h2AA); set_addr(3, 11'h7FF);
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem got en=%b we=%b want 0 0", mem_en, mem_we); end
    n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", load_ack); end
    n_cmp++; if (req_data_valid !== '0) begin n_bad++; $display("FAIL reset_rdv got %b want 0000", req_data_valid); end
    n_cmp++; if (conflict_count !== '0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", conflict_count); end
    req_valid = '0; host_we = 1'b0;
    reset = 1'b1;
    ptr_m = 0; cnt_m = '0; sbq.delete();
  endtask

  // Fixed request pattern held for n cycles; exp holds the required
  // one-hot grant of cycle c in bits [4c+3:4c].
  task automatic test_fixed(input string name, input logic [N-1:0] v, input int n, input logic [23:0] exp);
    rd_t e;
    int  g;
    for (int c = 0; c < n; c++) begin
      req_valid = v;
      #1;
      g = model_grant(v, ptr_m);
      n_cmp++; if (req_ready !== exp[4*c +: 4]) begin n_bad++; $display("FAIL %s_grant%0d got %b want %b", name, c, req_ready, exp[4*c +: 4]); end
      n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr_of(g)) begin
        n_bad++; $display("FAIL %s_mem%0d got en=%b we=%b addr=%h want 1 0 %h", name, c, mem_en, mem_we, mem_addr, addr_of(g));
      end
      model_cycle(g);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++; if (req_data_valid !== e.who) begin n_bad++; $display("FAIL %s_rdv%0d got %b want %b", name, c, req_data_valid, e.who); end
      n_cmp++; if (req_data !== e.data) begin n_bad++; $display("FAIL %s_data%0d got %h want %h", name, c, req_data, e.data); end
      n_cmp++; if (conflict_count !== cnt_m) begin n_bad++; $display("FAIL %s_cnt%0d got %0d want %0d", name, c, conflict_count, cnt_m); end
    end
    req_valid = '0;
  endtask

  task automatic test_load();
    rd_t e;
    // Request cycle: no grant, host write not yet honoured.
    req_valid = '1; load_req = 1'b1; host_we = 1'b1; host_addr = 11'h010; host_wdata = 16'hBEEF;
    #1;
    n_cmp++; if (req_ready !== '0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL load_block got ready=%b en=%b want 0000 0", req_ready, mem_en); end
    n_cmp++; if (load_ack !== 1'b0 || mem_wdata !== '0) begin n_bad++; $display("FAIL load_pre got ack=%b wdata=%h want 0 0000", load_ack, mem_wdata); end
    model_cycle(-1);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (req_data_valid !== e.who) begin n_bad++; $display("FAIL load_rdv0 got %b want %b", req_data_valid, e.who); end
    n_cmp++; if (load_ack !== 1'b1) begin n_bad++; $display("FAIL load_ack got %b want 1", load_ack); end
    // Host write.
    host_wdata = 16'h1234;
    #1;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL load_ready got %b want 0000", req_ready); end
    n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'h010 || mem_wdata !== 16'h1234) begin
      n_bad++; $display("FAIL load_write got en=%b we=%b addr=%h wdata=%h want 1 1 010 1234", mem_en, mem_we, mem_addr, mem_wdata);
    end
    exp_mem[16] = 16'h1234;
    model_cycle(-1);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (req_data_valid !== e.who) begin n_bad++; $display("FAIL load_rdv1 got %b want %b", req_data_valid, e.who); end
    // Release: still in load mode this cycle, host idle.
    host_we = 1'b0; load_req = 1'b0;
    #1;
    n_cmp++; if (mem_en !== 1'b0 || load_ack !== 1'b1 || req_ready !== '0) begin
      n_bad++; $display("FAIL load_idle got en=%b ack=%b ready=%b want 0 1 0000", mem_en, load_ack, req_ready);
    end
    model_cycle(-1);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (req_data_valid !== e.who) begin n_bad++; $display("FAIL load_rdv2 got %b want %b", req_data_valid, e.who); end
    n_cmp++; if (load_ack !== 1'b0) begin n_bad++; $display("FAIL load_exit got %b want 0", load_ack); end
    n_cmp++; if (conflict_count !== cnt_m) begin n_bad++; $display("FAIL load_cnt got %0d want %0d", conflict_count, cnt_m); end
    req_valid = '0;
    set_addr(0, 11'h010);
    test_fixed("readback", 4'b0001, 1, 24'h000001);
  endtask

  task automatic test_counter();
    rd_t e;
    int  g;
    req_valid = '1;
    for (int c = 0; c < 300; c++) begin
      #1;
      g = model_grant(req_valid, ptr_m);
      model_cycle(g);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++; if (req_data_valid !== e.who || req_data !== e.data) begin
        n_bad++; $display("FAIL sat_rd%0d got %b/%h want %b/%h", c, req_data_valid, req_data, e.who, e.data);
      end
    end
    n_cmp++; if (conflict_count !== 8'hFF) begin n_bad++; $display("FAIL sat_hold got %h want ff", conflict_count); end
    clear_stats = 1'b1;
    #1;
    g = model_grant(req_valid, ptr_m);
    model_cycle(g);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (conflict_count !== 8'h00) begin n_bad++; $display("FAIL clear_prio got %h want 00", conflict_count); end
    n_cmp++; if (req_data_valid !== e.who) begin n_bad++; $display("FAIL clear_rdv got %b want %b", req_data_valid, e.who); end
    clear_stats = 1'b0;
    #1;
    g = model_grant(req_valid, ptr_m);
    model_cycle(g);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (conflict_count !== 8'h01) begin n_bad++; $display("FAIL clear_resume got %h want 01", conflict_count); end
    n_cmp++; if (req_data !== e.data) begin n_bad++; $display("FAIL clear_data got %h want %h", req_data, e.data); end
    req_valid = '0;
  endtask

  task automatic test_random();
    rd_t           e;
    int            g;
    logic [N-1:0]  exp_oh;
    for (int c = 0; c < 60; c++) begin
      req_valid   = N'($urandom_range(0, 15));
      clear_stats = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) set_addr(i, AW'($urandom_range(0, 2047)));
      #1;
      g = model_grant(req_valid, ptr_m);
      exp_oh = '0;
      if (g >= 0) exp_oh[g] = 1'b1;
      n_cmp++; if (req_ready !== exp_oh) begin n_bad++; $display("FAIL rand_grant%0d got %b want %b (v=%b)", c, req_ready, exp_oh, req_valid); end
      n_cmp++; if (mem_en !== (g >= 0)) begin n_bad++; $display("FAIL rand_en%0d got %b want %b", c, mem_en, (g >= 0)); end
      model_cycle(g);
      @(posedge clk); #1;
      e = sbq.pop_front();
      n_cmp++; if (req_data_valid !== e.who) begin n_bad++; $display("FAIL rand_rdv%0d got %b want %b", c, req_data_valid, e.who); end
      if (e.who != '0) begin
        n_cmp++; if (req_data !== e.data) begin n_bad++; $display("FAIL rand_data%0d got %h want %h", c, req_data, e.data); end
      end
      n_cmp++; if (conflict_count !== cnt_m) begin n_bad++; $display("FAIL rand_cnt%0d got %0d want %0d", c, conflict_count, cnt_m); end
    end
    req_valid = '0; clear_stats = 1'b0;
  endtask

  task automatic test_async_reset();
    rd_t e;
    int  g;
    // In-flight read return cleared by reset without a clock edge.
    req_valid = 4'b0100;
    #1;
    g = model_grant(req_valid, ptr_m);
    model_cycle(g);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (req_data_valid !== 4'b0100) begin n_bad++; $display("FAIL inflight_rdv got %b want 0100", req_data_valid); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (req_data_valid !== '0 || req_ready !== '0 || mem_en !== 1'b0) begin
      n_bad++; $display("FAIL rst_inflight got rdv=%b ready=%b en=%b want 0000 0000 0", req_data_valid, req_ready, mem_en);
    end
    n_cmp++; if (conflict_count !== '0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", conflict_count); end
    #1 reset = 1'b1;
    sbq.delete(); ptr_m = 0; cnt_m = '0;
    // Reset mid-load.
    req_valid = '0; load_req = 1'b1;
    #1;
    model_cycle(-1);
    @(posedge clk); #1;
    e = sbq.pop_front();
    host_we = 1'b1; host_addr = 11'h040; host_wdata = 16'h0F0F;
    #1;
    n_cmp++; if (load_ack !== 1'b1 || mem_en !== 1'b1) begin n_bad++; $display("FAIL midload_pre got ack=%b en=%b want 1 1", load_ack, mem_en); end
    reset = 1'b0;
    #1;
    n_cmp++; if (load_ack !== 1'b0 || mem_en !== 1'b0 || req_ready !== '0 || req_data_valid !== '0) begin
      n_bad++; $display("FAIL midload_rst got ack=%b en=%b ready=%b rdv=%b want 0 0 0000 0000", load_ack, mem_en, req_ready, req_data_valid);
    end
    host_we = 1'b0; load_req = 1'b0;
    #1 reset = 1'b1;
    sbq.delete(); ptr_m = 0; cnt_m = '0;
    req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL post_rst_grant got %b want 0001", req_ready); end
    g = model_grant(req_valid, ptr_m);
    model_cycle(g);
    @(posedge clk); #1;
    e = sbq.pop_front();
    n_cmp++; if (req_data_valid !== e.who || req_data !== e.data) begin
      n_bad++; $display("FAIL post_rst_rd got %b/%h want %b/%h", req_data_valid, req_data, e.who, e.data);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fixed("rr", 4'b1111, 6, 24'b0010_0001_1000_0100_0010_0001);
    test_fixed("sparse", 4'b0011, 2, 24'h000021);
    test_fixed("single", 4'b0001, 1, 24'h000001);
    test_load();
    test_counter();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_arbiter.md
Name: fetch_arbiter

Overview:
- Shares one single-port instruction memory (1-cycle registered read) between NUM_REQ basic-block fetch ports, using round-robin arbitration.
- Also provides a host program-load mode: requester grants are suspended and the host writes instruction words.
- Sits between the basic-block array and the instruction BRAM.
- Keeps a saturating fetch-conflict counter for performance tuning.

Parameters:
- NUM_REQ, 4, number of fetch requesters (≥1).
- MEMORY_WIDTH, 16, instruction word width.
- MEMORY_ADDR_WIDTH, 11, memory address width.
- CNT_WIDTH, 16, conflict counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester fetch request.
- req_addr  in  NUM_REQ*MEMORY_ADDR_WIDTH  packed addresses; requester i uses bits [i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- req_data  out  MEMORY_WIDTH  shared read data, mem_rdata passthrough.
- req_data_valid  out  NUM_REQ  registered one-hot: requester whose data is on req_data this cycle.
- load_req  in  1  host requests program-load mode.
- load_ack  out  1  high while in load mode.
- host_we  in  1  host write strobe (honoured only when load_ack=1).
- host_addr  in  MEMORY_ADDR_WIDTH  host write address.
- host_wdata  in  MEMORY_WIDTH  host write data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEMORY_ADDR_WIDTH  memory address.
- mem_wdata  out  MEMORY_WIDTH  memory write data.
- mem_rdata  in  MEMORY_WIDTH  memory read data, valid 1 cycle after mem_en & ~mem_we.
- clear_stats  in  1  synchronous clear of conflict_count.
- conflict_count  out  CNT_WIDTH  saturating conflict counter.

Behaviour:
- Reset (reset=0, asynchronous): state=S_RUN, rr_ptr=0, req_data_valid=0, conflict_count=0. Combinational outputs while in reset: req_ready=0, mem_en=0, mem_we=0, load_ack=0.
- States:
  - S_RUN: arbitration active.
  - S_LOAD: host owns memory.
  - S_RUN→S_LOAD when load_req=1. S_LOAD→S_RUN when load_req=0. Each transition takes effect on the next edge.
- Arbitration (S_RUN and load_req=0):
  - g = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … cyclically modulo NUM_REQ.
  - Outputs: req_ready[g]=1, all other bits 0; mem_en=1, mem_we=0, mem_addr=req_addr[g].
  - Next edge: rr_ptr <= (g+1) mod NUM_REQ.
  - No valid requester: mem_en=0, req_ready=0, rr_ptr held.
  - req_ready never depends on req_ready of other ports; a requester may drop req_valid at any time without penalty.
- Blocking: load_req=1 in S_RUN gives no grant that cycle (req_ready=0, mem_en=0). This gives a clean one-cycle handover.
- Load mode (S_LOAD):
  - load_ack=1, req_ready=0.
  - mem_en=mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
  - host_we is ignored (mem_en=0) whenever load_ack=0.
  - mem_wdata=0 outside load mode.
- Read return:
  - req_data=mem_rdata in every cycle.
  - req_data_valid <= req_ready (registered); it is all-zero in the cycle after a load-mode cycle or an idle cycle.
  - A granted requester samples req_data in the cycle after its grant, matching the basic-block FETCH_SEND→FETCH_REC timing.
- Conflict counter:
  - Increments on an edge where a grant was issued and popcount(req_valid) ≥ 2.
  - Saturates at all-ones.
  - clear_stats=1 forces 0 and takes priority over increment.
- NUM_REQ=1: rr_ptr is constant 0 (1-bit register); the counter never increments.
- Reset asserted mid-load: returns to S_RUN; any in-flight req_data_valid is cleared immediately.

Test Plan:
- Single requester: req_valid=4'b0001, addr 0x005 → req_ready=0001 same cycle, mem_addr=0x005; next cycle req_data_valid=0001 and req_data=mem[5].
- All four requesting continuously from reset → grants 0,1,2,3,0,1 on consecutive cycles; conflict_count increments every cycle.
- Sparse pattern: rr_ptr=2, req_valid=4'b0011 → grant to requester 0, rr_ptr becomes 1; next cycle same requests → grant to requester 1.
- Load: load_req=1 while req_valid=1111 → no grant that cycle; load_ack=1 next cycle. host_we writes 0x1234 to 0x010, mem_we=1 that cycle. load_req=0, then requester 0 reads 0x010 → req_data=0x1234.
- Counter: preload to all-ones by holding conflicts → stays all-ones; clear_stats with a concurrent conflict → 0.
- Async reset mid-load (reset=0 between clock edges) → load_ack, req_ready and req_data_valid go 0 without a clock edge; after release the first grant goes to requester 0.
